// File: rtl/sprite_mover.sv
// Sprite mover: optionally erases a sprite, steps it one move left/right, and redraws it.
// Pixels stream from a synchronous sprite ROM into a VGA-style plot port.
module sprite_mover #(
    parameter int          SPR_W         = 28,
    parameter int          SPR_H         = 20,
    parameter int          ADDR_W        = 10,
    parameter int          X_INIT        = 146,
    parameter int          X_MIN         = 0,
    parameter int          X_MAX         = 292,
    parameter int          STEP          = 1,
    parameter logic [2:0]  ERASE_COLOUR  = 3'b000,
    parameter bit          TRANSP_EN     = 1'b0,
    parameter logic [2:0]  TRANSP_COLOUR = 3'b111
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              move_req,
    input  logic              move_dir,
    input  logic [7:0]        y_pos,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [2:0]        rom_q,
    output logic [8:0]        x_out,
    output logic [7:0]        y_out,
    output logic [2:0]        colour,
    output logic              plot,
    output logic [8:0]        x_cur,
    output logic              busy,
    output logic              done
);

    localparam int NPIX = SPR_W * SPR_H;
    localparam int CW   = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int RW   = (SPR_H > 1) ? $clog2(SPR_H) : 1;

    typedef enum logic [2:0] {StIdle, StErase, StMove, StDraw, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] k_q, k_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic              drain_q, drain_d;
    logic [8:0]        x_q, x_d;
    logic [8:0]        tgt_q, tgt_d;
    logic [7:0]        y_q, y_d;
    // Pipeline stage aligned with rom_q: holds coordinates of the pixel being plotted.
    logic              pv_q, pv_d;
    logic              perase_q, perase_d;
    logic [8:0]        px_q, px_d;
    logic [7:0]        py_q, py_d;
    int                tgt_int;

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        col_d    = col_q;
        row_d    = row_q;
        drain_d  = drain_q;
        x_d      = x_q;
        tgt_d    = tgt_q;
        y_d      = y_q;
        pv_d     = 1'b0;
        perase_d = perase_q;
        px_d     = px_q;
        py_d     = py_q;
        rom_addr = '0;

        tgt_int = move_dir ? (int'(x_q) + STEP) : (int'(x_q) - STEP);
        if (tgt_int < X_MIN) tgt_int = X_MIN;
        if (tgt_int > X_MAX) tgt_int = X_MAX;

        case (state_q)
            StIdle: begin
                if (start) begin
                    y_d   = y_pos;
                    tgt_d = 9'(tgt_int);
                    if (move_req && (9'(tgt_int) != x_q)) state_d = StErase;
                    else                                   state_d = StDraw;
                end
            end
            StErase, StDraw: begin
                if (drain_q) begin
                    drain_d = 1'b0;
                    state_d = (state_q == StErase) ? StMove : StDone;
                end else begin
                    rom_addr = k_q;
                    pv_d     = 1'b1;
                    perase_d = (state_q == StErase);
                    px_d     = x_q + 9'(col_q);
                    py_d     = y_q + 8'(row_q);
                    if (k_q == ADDR_W'(NPIX - 1)) begin
                        k_d     = '0;
                        col_d   = '0;
                        row_d   = '0;
                        drain_d = 1'b1;
                    end else begin
                        k_d = k_q + ADDR_W'(1);
                        if (col_q == CW'(SPR_W - 1)) begin
                            col_d = '0;
                            row_d = row_q + RW'(1);
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                    end
                end
            end
            StMove: begin
                x_d     = tgt_q;
                state_d = StDraw;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= StIdle;
            k_q      <= '0;
            col_q    <= '0;
            row_q    <= '0;
            drain_q  <= 1'b0;
            x_q      <= 9'(X_INIT);
            tgt_q    <= '0;
            y_q      <= '0;
            pv_q     <= 1'b0;
            perase_q <= 1'b0;
            px_q     <= '0;
            py_q     <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            col_q    <= col_d;
            row_q    <= row_d;
            drain_q  <= drain_d;
            x_q      <= x_d;
            tgt_q    <= tgt_d;
            y_q      <= y_d;
            pv_q     <= pv_d;
            perase_q <= perase_d;
            px_q     <= px_d;
            py_q     <= py_d;
        end
    end

    // Colour and plot are combinational on rom_q so they line up with the ROM's one-cycle latency.
    assign colour = pv_q ? (perase_q ? ERASE_COLOUR : rom_q) : 3'b000;
    assign plot   = pv_q && !(TRANSP_EN && !perase_q && (rom_q == TRANSP_COLOUR));
    assign x_out  = px_q;
    assign y_out  = py_q;
    assign x_cur  = x_q;
    assign busy   = (state_q != StIdle);
    assign done   = (state_q == StDone);

endmodule
